// File: rtl/rdout_acc.sv
// rdout_acc: multi-lane readout accumulator.
// Sums NCHUNK signed partial-sum chunks per lane into a wide accumulator,
// clips each lane to QW bits, then holds the result until the consumer takes it.
// Optional feature: define RDOUT_ACC_BIAS_EN to add a per-lane 'bias' input whose
// sign-extended value seeds the accumulators on every clear instead of zero.
module rdout_acc #(
    parameter int QW     = 32,
    parameter int NOUT   = 2,
    parameter int NCHUNK = 16,
    parameter int AW     = QW + $clog2(NCHUNK) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ce,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NOUT*QW-1:0]        in_q,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NOUT*QW-1:0]        out_y,
    output logic [NOUT-1:0]           sat,
    output logic [$clog2(NCHUNK)-1:0] chunk_cnt
`ifdef RDOUT_ACC_BIAS_EN
    ,
    input  logic [NOUT*QW-1:0]        bias
`endif
);

    localparam int CW = $clog2(NCHUNK);
    localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);

    localparam logic [1:0] ST_ACC  = 2'd0;
    localparam logic [1:0] ST_SAT  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-QW+1){1'b0}}, {(QW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-QW+1){1'b1}}, {(QW-1){1'b0}}};

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [AW-1:0]   acc_q    [NOUT];
    logic signed [AW-1:0]   acc_d    [NOUT];
    logic signed [AW-1:0]   acc_base [NOUT];
    logic signed [AW-1:0]   acc_clr  [NOUT];
    logic [NOUT*QW-1:0]     out_y_q, out_y_d;
    logic [NOUT-1:0]        sat_q, sat_d;
    logic                   accept;
    logic                   hold_done;

    function automatic logic signed [AW-1:0] sext(input logic [QW-1:0] v);
        return {{(AW-QW){v[QW-1]}}, v};
    endfunction

    assign accept    = ce & in_valid & (state_q == ST_ACC);
    assign hold_done = ce & out_ready & (state_q == ST_HOLD);

`ifdef RDOUT_ACC_BIAS_EN
    logic bias_load_q, bias_load_d;

    // After reset the bias has not been loaded yet; the first enabled cycle loads it
    always_comb begin
        bias_load_d = bias_load_q & ~ce;
    end

    // Pending-bias flag, set by reset and cleared once the bias has been applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_load_q <= 1'b1;
        end else begin
            bias_load_q <= bias_load_d;
        end
    end
`endif

    // Value each lane returns to on a clear: the bias when built with it, else zero
    always_comb begin
        for (int k = 0; k < NOUT; k++) begin
`ifdef RDOUT_ACC_BIAS_EN
            acc_clr[k] = sext(bias[k*QW +: QW]);
`else
            acc_clr[k] = '0;
`endif
        end
    end

    // Starting point for this cycle's add; a pending bias load replaces the stored sum
    always_comb begin
        for (int k = 0; k < NOUT; k++) begin
`ifdef RDOUT_ACC_BIAS_EN
            acc_base[k] = bias_load_q ? acc_clr[k] : acc_q[k];
`else
            acc_base[k] = acc_q[k];
`endif
        end
    end

    // FSM and chunk counter: the last chunk of a vector wraps the count and moves to SAT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SAT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_SAT: begin
                if (ce) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_done) begin
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // Accumulators add sign-extended chunks in ACC and are cleared when a result is taken
    always_comb begin
        for (int k = 0; k < NOUT; k++) begin
            acc_d[k] = acc_q[k];
            if (hold_done) begin
                acc_d[k] = acc_clr[k];
            end else if (ce && (state_q == ST_ACC)) begin
                acc_d[k] = acc_base[k] + (accept ? sext(in_q[k*QW +: QW]) : '0);
            end
        end
    end

    // Clip each wide sum into the QW-bit output range and flag lanes that were clipped
    always_comb begin
        out_y_d = out_y_q;
        sat_d   = sat_q;
        if (ce && (state_q == ST_SAT)) begin
            for (int k = 0; k < NOUT; k++) begin
                if (acc_q[k] > SAT_MAX) begin
                    out_y_d[k*QW +: QW] = SAT_MAX[QW-1:0];
                    sat_d[k]            = 1'b1;
                end else if (acc_q[k] < SAT_MIN) begin
                    out_y_d[k*QW +: QW] = SAT_MIN[QW-1:0];
                    sat_d[k]            = 1'b1;
                end else begin
                    out_y_d[k*QW +: QW] = acc_q[k][QW-1:0];
                    sat_d[k]            = 1'b0;
                end
            end
        end
    end

    // State registers; reset discards any partially accumulated vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            cnt_q   <= '0;
            out_y_q <= '0;
            sat_q   <= '0;
            for (int k = 0; k < NOUT; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_y_q <= out_y_d;
            sat_q   <= sat_d;
            for (int k = 0; k < NOUT; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign out_y     = out_y_q;
    assign sat       = sat_q;
    assign chunk_cnt = cnt_q;

endmodule

// File: tb/tb_rdout_acc.sv
// tb_rdout_acc: self-checking bench for rdout_acc (QW=32, NOUT=2, NCHUNK=4).
// Expected results come from a plain-arithmetic model: bias plus the sum of the
// chunks in 64-bit integers, then clipped to the signed 32-bit range.
module tb_rdout_acc;

    localparam int QW   = 32;
    localparam int NOUT = 2;
    localparam int NCH  = 4;

    localparam longint QMAX = 64'sd2147483647;
    localparam longint QMIN = -64'sd2147483648;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ce;
    logic               in_valid;
    logic               in_ready;
    logic [NOUT*QW-1:0] in_q;
    logic               out_valid;
    logic               out_ready;
    logic [NOUT*QW-1:0] out_y;
    logic [NOUT-1:0]    sat;
    logic [1:0]         chunk_cnt;

    logic signed [QW-1:0] bias_lane [NOUT];
    logic signed [QW-1:0] ch [NOUT][NCH];
    logic [NOUT*QW-1:0]   exp_y;
    logic [NOUT-1:0]      exp_sat;

    int total = 0;
    int bad   = 0;

`ifdef RDOUT_ACC_BIAS_EN
    logic [NOUT*QW-1:0] bias;
    assign bias = {bias_lane[1], bias_lane[0]};
`endif

    rdout_acc #(
        .QW     (QW),
        .NOUT   (NOUT),
        .NCHUNK (NCH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .sat       (sat),
        .chunk_cnt (chunk_cnt)
`ifdef RDOUT_ACC_BIAS_EN
        ,
        .bias      (bias)
`endif
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends even if something stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: bias + sum of chunks in wide arithmetic, clipped to 32 bits
    task automatic compute_expected();
        longint s;
        for (int k = 0; k < NOUT; k++) begin
            s = longint'(bias_lane[k]);
            for (int i = 0; i < NCH; i++) begin
                s += longint'(ch[k][i]);
            end
            if (s > QMAX) begin
                exp_y[k*QW +: QW] = 32'h7FFF_FFFF;
                exp_sat[k]        = 1'b1;
            end else if (s < QMIN) begin
                exp_y[k*QW +: QW] = 32'h8000_0000;
                exp_sat[k]        = 1'b1;
            end else begin
                exp_y[k*QW +: QW] = s[31:0];
                exp_sat[k]        = 1'b0;
            end
        end
    endtask

    task automatic fill_random(input int mode);
        for (int k = 0; k < NOUT; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if (mode == 0) begin
                    ch[k][i] = int'($urandom_range(0, 2000)) - 1000;
                end else if (mode == 1) begin
                    ch[k][i] = $urandom;
                end else begin
                    ch[k][i] = ($urandom_range(0, 1) == 1) ? 32'sh7FFF_FF00 + int'($urandom_range(0, 255))
                                                           : 32'sh8000_0000 + int'($urandom_range(0, 255));
                end
            end
        end
    endtask

    // Drive one full vector back-to-back; returns just after the last accept edge
    task automatic feed_vector();
        for (int i = 0; i < NCH; i++) begin
            in_q     = {ch[1][i], ch[0][i]};
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (out_y !== '0) begin bad++; $display("[TB] FAIL rst_out_y got=%h want=0", out_y); end
        total++; if (sat !== 2'b00) begin bad++; $display("[TB] FAIL rst_sat got=%b want=00", sat); end
        total++; if (chunk_cnt !== 2'd0) begin bad++; $display("[TB] FAIL rst_cnt got=%0d want=0", chunk_cnt); end
        rst_n = 1'b1;
        // two chunks of a vector that reset will throw away
        fill_random(0);
        for (int i = 0; i < 2; i++) begin
            in_q     = {ch[1][i], ch[0][i]};
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        total++; if (chunk_cnt !== 2'd2) begin bad++; $display("[TB] FAIL midvec_cnt got=%0d want=2", chunk_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (chunk_cnt !== 2'd0) begin bad++; $display("[TB] FAIL async_rst_cnt got=%0d want=0", chunk_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL async_rst_in_ready got=%b want=1", in_ready); end
        total++; if ({out_valid, sat, out_y} !== '0) begin bad++; $display("[TB] FAIL async_rst_outs got=%h want=0", {out_valid, sat, out_y}); end
        tick();
        rst_n = 1'b1;
        fill_random(1);
        compute_expected();
        feed_vector();
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL post_rst_valid got=%b want=1", out_valid); end
        total++; if (out_y !== exp_y) begin bad++; $display("[TB] FAIL post_rst_y got=%h want=%h", out_y, exp_y); end
        total++; if (sat !== exp_sat) begin bad++; $display("[TB] FAIL post_rst_sat got=%b want=%b", sat, exp_sat); end
        release_result();
    endtask

    task automatic test_basic_sum();
        for (int i = 0; i < NCH; i++) begin
            ch[0][i] = i + 1;
            ch[1][i] = -(i + 1);
        end
        compute_expected();
        feed_vector();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_early_valid got=%b want=0", out_valid); end
        total++; if (chunk_cnt !== 2'd0) begin bad++; $display("[TB] FAIL basic_cnt_wrap got=%0d want=0", chunk_cnt); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL basic_sat_ready got=%b want=0", in_ready); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_latency got=%b want=1", out_valid); end
        total++; if (out_y !== exp_y) begin bad++; $display("[TB] FAIL basic_y got=%h want=%h", out_y, exp_y); end
        total++; if (out_y !== 64'hFFFF_FFF6_0000_000A) begin bad++; $display("[TB] FAIL basic_y_const got=%h want=fffffff60000000a", out_y); end
        total++; if (sat !== 2'b00) begin bad++; $display("[TB] FAIL basic_sat got=%b want=00", sat); end
        release_result();
        total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("[TB] FAIL basic_release got=%b want=10", {in_ready, out_valid}); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < NCH; i++) begin
            ch[0][i] = 32'sh7FFF_FFFF;
            ch[1][i] = 32'sh8000_0000;
        end
        compute_expected();
        feed_vector();
        tick();
        total++; if (out_y !== 64'h8000_0000_7FFF_FFFF) begin bad++; $display("[TB] FAIL sat_y got=%h want=800000007fffffff", out_y); end
        total++; if (sat !== 2'b11) begin bad++; $display("[TB] FAIL sat_flags got=%b want=11", sat); end
        total++; if (out_y !== exp_y) begin bad++; $display("[TB] FAIL sat_model_y got=%h want=%h", out_y, exp_y); end
        release_result();
    endtask

    task automatic test_backpressure();
        fill_random(0);
        compute_expected();
        feed_vector();
        tick();
        for (int c = 0; c < 5; c++) begin
            in_q     = {$urandom, $urandom};
            in_valid = 1'b1;
            tick();
            total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready c=%0d got=%b want=0", c, in_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid c=%0d got=%b want=1", c, out_valid); end
            total++; if (out_y !== exp_y) begin bad++; $display("[TB] FAIL bp_y c=%0d got=%h want=%h", c, out_y, exp_y); end
            total++; if (chunk_cnt !== 2'd0) begin bad++; $display("[TB] FAIL bp_cnt c=%0d got=%0d want=0", c, chunk_cnt); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("[TB] FAIL bp_release got=%b want=10", {in_ready, out_valid}); end
        fill_random(0);
        compute_expected();
        feed_vector();
        tick();
        total++; if (out_y !== exp_y) begin bad++; $display("[TB] FAIL bp_next_y got=%h want=%h", out_y, exp_y); end
        release_result();
    endtask

    task automatic test_ce_stall();
        fill_random(0);
        compute_expected();
        for (int i = 0; i < 2; i++) begin
            in_q     = {ch[1][i], ch[0][i]};
            in_valid = 1'b1;
            tick();
        end
        in_q = {ch[1][2], ch[0][2]};
        ce   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (chunk_cnt !== 2'd2) begin bad++; $display("[TB] FAIL stall_cnt c=%0d got=%0d want=2", c, chunk_cnt); end
        end
        ce = 1'b1;
        tick();
        in_q = {ch[1][3], ch[0][3]};
        tick();
        in_valid = 1'b0;
        ce       = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_sat got=%b want=0", out_valid); end
        ce = 1'b1;
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid got=%b want=1", out_valid); end
        total++; if (out_y !== exp_y) begin bad++; $display("[TB] FAIL stall_y got=%h want=%h", out_y, exp_y); end
        out_ready = 1'b1;
        ce        = 1'b0;
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_handshake got=%b want=1", out_valid); end
        ce = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_release got=%b want=0", out_valid); end
    endtask

    task automatic test_random();
        int wait_n;
        for (int v = 0; v < 20; v++) begin
            fill_random(int'($urandom_range(0, 2)));
            compute_expected();
            feed_vector();
            tick();
            wait_n = int'($urandom_range(0, 3));
            for (int w = 0; w < wait_n; w++) begin
                tick();
            end
            total++; if (out_y !== exp_y) begin bad++; $display("[TB] FAIL rand_y v=%0d got=%h want=%h", v, out_y, exp_y); end
            total++; if (sat !== exp_sat) begin bad++; $display("[TB] FAIL rand_sat v=%0d got=%b want=%b", v, sat, exp_sat); end
            release_result();
        end
    endtask

`ifdef RDOUT_ACC_BIAS_EN
    task automatic test_bias();
        bias_lane[0] = 32'sd100;
        bias_lane[1] = -32'sd7;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            ch[0][i] = i + 1;
            ch[1][i] = int'($urandom_range(0, 200)) - 100;
        end
        compute_expected();
        feed_vector();
        tick();
        total++; if (out_y[31:0] !== 32'd110) begin bad++; $display("[TB] FAIL bias_lane0 got=%0d want=110", out_y[31:0]); end
        total++; if (out_y !== exp_y) begin bad++; $display("[TB] FAIL bias_y got=%h want=%h", out_y, exp_y); end
        release_result();
        fill_random(0);
        compute_expected();
        feed_vector();
        tick();
        total++; if (out_y !== exp_y) begin bad++; $display("[TB] FAIL bias_reload_y got=%h want=%h", out_y, exp_y); end
        release_result();
    endtask
`endif

    initial begin
        ce           = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        in_q         = '0;
        rst_n        = 1'b0;
        bias_lane[0] = '0;
        bias_lane[1] = '0;
        $display("[TB] starting rdout_acc bench");
        test_reset();
        test_basic_sum();
        test_saturation();
        test_backpressure();
        test_ce_stall();
        test_random();
`ifdef RDOUT_ACC_BIAS_EN
        test_bias();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rdout_acc.md
RDOUT_ACC -- requirements
Module: rdout_acc

Interface
- REQ-001 SHALL have parameter QW, 32, signed width of each incoming partial-sum lane and each output lane.
- REQ-002 SHALL have parameter NOUT, 2, number of readout lanes.
- REQ-003 SHALL have parameter NCHUNK, 16, partial-sum chunks per output vector (NCHUNK >= 2).
- REQ-004 SHALL have parameter AW, QW+$clog2(NCHUNK)+1, signed internal accumulator width per lane.
- REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
- REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
- REQ-007 SHALL have port ce  input  1  clock enable; low freezes all state.
- REQ-008 SHALL have port in_valid  input  1  in_q carries a valid partial-sum chunk.
- REQ-009 SHALL have port in_ready  output  1  block can accept a chunk.
- REQ-010 SHALL have port in_q  input  NOUT*QW  signed partial sums, lane k at [(k+1)*QW-1 -: QW].
- REQ-011 SHALL have port out_valid  output  1  out_y holds a completed result.
- REQ-012 SHALL have port out_ready  input  1  consumer accepts out_y.
- REQ-013 SHALL have port out_y  output  NOUT*QW  saturated signed results, same lane packing as in_q.
- REQ-014 SHALL have port sat  output  NOUT  per-lane flag, 1 = lane k was clipped.
- REQ-015 SHALL have port chunk_cnt  output  $clog2(NCHUNK)  number of chunks accepted in the current vector.

Function
- REQ-016 SHALL implement a three-state FSM: ACC, SAT, HOLD.
- REQ-017 SHALL accept a chunk when ce & in_valid & in_ready, where in_ready = (state==ACC).
- REQ-018 SHALL, on accept, sign-extend each lane of in_q to AW and add it to that lane's accumulator.
- REQ-019 SHALL increment chunk_cnt on each accept; on the NCHUNK-th accept, reset chunk_cnt to 0 and go ACC->SAT.
- REQ-020 SHALL, in SAT, clip each lane to [-2^(QW-1), 2^(QW-1)-1], register the result into out_y and sat, and go SAT->HOLD; accept to out_valid latency SHALL be exactly 2 cycles.
- REQ-021 SHALL hold out_valid=1 in HOLD, with out_y and sat stable until ce & out_ready.
- REQ-022 SHALL, on ce & out_ready in HOLD, clear the accumulators, drop out_valid and return to ACC in the next cycle.
- REQ-023 SHALL ignore in_valid in SAT and HOLD, with no accumulation and no count change.
- REQ-024 SHALL freeze FSM, accumulators, counter and outputs for every cycle ce=0, including across handshake cycles.
- REQ-025 SHALL NOT wrap the accumulators within one vector, given AW as defined.

Reset
- REQ-026 SHALL, on rst_n=0 at any time including mid-vector, asynchronously force state=ACC, accumulators=0, chunk_cnt=0, out_valid=0, out_y=0, sat=0.
- REQ-027 SHALL drive in_ready=1 while and after reset, following state==ACC.
- REQ-028 SHALL discard a partially accumulated vector on reset.

Configuration
- REQ-029 SHALL provide macro RDOUT_ACC_BIAS_EN; when defined, the block SHALL add input port bias (NOUT*QW, signed) and load each accumulator with sign-extended bias on reset-release clear and on the HOLD->ACC clear.
- REQ-030 SHALL, when RDOUT_ACC_BIAS_EN is undefined, have no bias port and clear the accumulators to 0.

Verification
- REQ-031 SHALL check reset: rst_n low mid-vector (chunk_cnt=2) -> all outputs 0, in_ready=1; next full vector is correct.
- REQ-032 SHALL check basic sum: NCHUNK=4, lane0 chunks 1,2,3,4 and lane1 chunks -1,-2,-3,-4 -> out_y lane0=10, lane1=-10, sat=00, out_valid 2 cycles after the 4th accept.
- REQ-033 SHALL check saturation: lane0 4x 0x7FFFFFFF -> 0x7FFFFFFF, sat[0]=1; lane1 4x 0x80000000 -> 0x80000000, sat[1]=1.
- REQ-034 SHALL check backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_y stable, no accumulation; out_ready=1 -> ACC next cycle, next vector starts from 0.
- REQ-035 SHALL check ce stall: ce=0 for 3 cycles mid-vector with in_valid=1 -> chunk_cnt and sums unchanged; final result equals the unstalled result.
- REQ-036 SHALL check bias, with RDOUT_ACC_BIAS_EN defined: bias lane0=100, chunks 1,2,3,4 -> out_y lane0=110.
